ser_to_block128: RTL and testbench

- Deserialiser directly downstream of the Para_to_Ser link stage.
- Samples a 1-bit serial stream, packs bits into bytes, and packs bytes into a 128-bit AES state block for the cipher core.
- Holds each completed block in an output register with a valid/ack handshake.
- Flags overrun when a new block completes before the consumer acknowledges the previous one.

---
 rtl/ser_to_block128_if.sv | 24 ++
 rtl/ser_to_block128.sv | 121 ++++++++++++
 tb/tb_ser_to_block128.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ser_to_block128_if.sv
// Bundles the serial input, control strobes and block handshake of the
// ser_to_block128 deserialiser; the design uses the slave side.
interface ser_to_block128_if #(
  parameter int NBYTES = 16
);
  logic                  enable;
  logic                  DataIN;
  logic                  frame_sync;
  logic                  block_ack;
  logic [8*NBYTES-1:0]   DataOUT;
  logic                  block_valid;
  logic                  byte_done;
  logic                  overrun;

  modport master (
    output enable, DataIN, frame_sync, block_ack,
    input  DataOUT, block_valid, byte_done, overrun
  );

  modport slave (
    input  enable, DataIN, frame_sync, block_ack,
    output DataOUT, block_valid, byte_done, overrun
  );
endinterface

// File: rtl/ser_to_block128.sv
// Serial-to-block deserialiser: packs a 1-bit stream into bytes, then into an
// NBYTES-wide block held for the consumer behind a valid/ack handshake.
module ser_to_block128 #(
  parameter int NBYTES    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               RST,
  ser_to_block128_if.slave   bus
);
  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [2:0]      r_bitCnt;
  logic [2:0]      w_bitBase;
  logic [CW-1:0]   r_byteCnt;
  logic [CW-1:0]   w_byteCntBase;
  logic [7:0]      r_byte;
  logic [7:0]      w_byteBase;
  logic [7:0]      w_newByte;
  logic [W-1:0]    r_block;
  logic [W-1:0]    w_blockBase;
  logic [W-1:0]    w_newBlock;
  logic [W-1:0]    r_dataOut;
  logic            r_valid;
  logic            r_byteDone;
  logic            r_overrun;
  logic            w_byteFull;
  logic            w_blockFull;

  // frame_sync clears assembly before the bit on the same edge is taken, so
  // every assembly decision works from these "after clear" views.
  always_comb begin
    w_bitBase     = bus.frame_sync ? 3'd0      : r_bitCnt;
    w_byteCntBase = bus.frame_sync ? '0        : r_byteCnt;
    w_byteBase    = bus.frame_sync ? 8'd0      : r_byte;
    w_blockBase   = bus.frame_sync ? '0        : r_block;
    w_newByte     = MSB_FIRST ? {w_byteBase[6:0], bus.DataIN}
                              : {bus.DataIN, w_byteBase[7:1]};
    w_newBlock    = {w_blockBase[W-9:0], w_newByte};
    w_byteFull    = bus.enable && (w_bitBase == 3'd7);
    w_blockFull   = w_byteFull && (w_byteCntBase == LAST_BYTE);
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.enable) w_nextState = RECV;
      RECV: begin
        if (bus.frame_sync && !bus.enable) w_nextState = IDLE;
        else if (w_blockFull)              w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      r_bitCnt   <= 3'd0;
      r_byteCnt  <= '0;
      r_byte     <= 8'd0;
      r_block    <= '0;
      r_dataOut  <= '0;
      r_valid    <= 1'b0;
      r_byteDone <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_byteDone <= 1'b0;
      if (bus.enable) begin
        r_bitCnt <= w_bitBase + 3'd1;
        if (w_byteFull) begin
          r_byte     <= 8'd0;
          r_byteDone <= 1'b1;
          if (w_blockFull) begin
            r_byteCnt <= '0;
            r_block   <= '0;
          end else begin
            r_byteCnt <= w_byteCntBase + CW'(1);
            r_block   <= w_newBlock;
          end
        end else begin
          r_byte    <= w_newByte;
          r_byteCnt <= w_byteCntBase;
          r_block   <= w_blockBase;
        end
      end else if (bus.frame_sync) begin
        r_bitCnt  <= 3'd0;
        r_byteCnt <= '0;
        r_byte    <= 8'd0;
        r_block   <= '0;
      end

      // A held, unacknowledged block wins over a newly completed one.
      if (w_blockFull) begin
        if (!r_valid || bus.block_ack) begin
          r_dataOut <= w_newBlock;
          r_valid   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (bus.block_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.DataOUT     = r_dataOut;
  assign bus.block_valid = r_valid;
  assign bus.byte_done   = r_byteDone;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_ser_to_block128.sv
// Randomised self-checking bench: a bit-queue reference model tracks the
// expected outputs every cycle, plus literal checks from the test plan.
module tb_ser_to_block128;
  localparam int NB = 16;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic RST;
  int   nCompared = 0;
  int   nMismatch = 0;

  ser_to_block128_if #(.NBYTES(NB)) bus ();

  ser_to_block128 #(.NBYTES(NB), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  bit           mq[$];
  logic [W-1:0] mData;
  logic         mValid;
  logic         mByteDone;
  logic         mOverrun;

  function automatic logic [W-1:0] packBits();
    logic [W-1:0] blk;
    blk = '0;
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8; j++)
        blk[W-1-8*k-j] = mq[8*k+j];
    return blk;
  endfunction

  task automatic modelStep(input logic r, input logic e, input logic d,
                           input logic f, input logic a);
    logic         done;
    logic [W-1:0] blk;
    done = 1'b0;
    blk  = '0;
    if (!r) begin
      mq.delete();
      mData = '0; mValid = 1'b0; mByteDone = 1'b0; mOverrun = 1'b0;
      return;
    end
    mByteDone = 1'b0;
    if (f) mq.delete();
    if (e) begin
      mq.push_back(d);
      if (mq.size() % 8 == 0) mByteDone = 1'b1;
      if (mq.size() == W) begin
        blk  = packBits();
        done = 1'b1;
        mq.delete();
      end
    end
    if (done) begin
      if (!mValid || a) begin
        mData  = blk;
        mValid = 1'b1;
      end else begin
        mOverrun = 1'b1;
      end
    end else if (a) begin
      mValid = 1'b0;
    end
  endtask

  task automatic cmp(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("DataOUT",     bus.DataOUT,           mData);
    cmp("block_valid", W'(bus.block_valid),   W'(mValid));
    cmp("byte_done",   W'(bus.byte_done),     W'(mByteDone));
    cmp("overrun",     W'(bus.overrun),       W'(mOverrun));
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic d,
                               input logic f, input logic a);
    RST            = r;
    bus.enable     = e;
    bus.DataIN     = d;
    bus.frame_sync = f;
    bus.block_ack  = a;
    @(posedge clk);
    modelStep(r, e, d, f, a);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic ackLast);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, b[7-i], 1'b0, ackLast && (i == 7));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendRandomBlock(output logic [W-1:0] blk, input logic ackLast);
    logic [7:0] b;
    blk = '0;
    for (int k = 0; k < NB; k++) begin
      b   = 8'($urandom);
      blk = {blk[W-9:0], b};
      sendByte(b, ackLast && (k == NB - 1));
    end
  endtask

  logic [W-1:0] blkA;
  logic [W-1:0] blkB;
  logic [W-1:0] blkC;
  logic [W-1:0] snap;
  logic [7:0]   c3;

  initial begin
    // Reset with random inputs, then release while idle
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    cmp("reset DataOUT", bus.DataOUT, '0);
    cmp("reset overrun", W'(bus.overrun), W'(0));
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    cmp("idle valid", W'(bus.block_valid), W'(0));

    // Single byte 8'h2B
    sendByte(8'h2B, 1'b0);
    cmp("2B byte_done", W'(bus.byte_done), W'(1));
    idle(1);
    cmp("2B byte_done clear", W'(bus.byte_done), W'(0));
    cmp("2B no valid", W'(bus.block_valid), W'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Full block 00..0F
    for (int k = 0; k < NB; k++) sendByte(8'(k), 1'b0);
    cmp("full valid", W'(bus.block_valid), W'(1));
    cmp("full DataOUT", bus.DataOUT, 128'h000102030405060708090A0B0C0D0E0F);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp("ack clears valid", W'(bus.block_valid), W'(0));
    cmp("ack keeps DataOUT", bus.DataOUT, 128'h000102030405060708090A0B0C0D0E0F);

    // Pause mid-byte, then resync
    c3 = 8'hC3;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, c3[7-i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b1, c3[7-i], 1'b0, 1'b0);
    for (int k = 1; k < NB; k++) sendByte(8'($urandom), 1'b0);
    cmp("pause first byte", W'(bus.DataOUT[W-1 -: 8]), W'(8'hC3));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
    blkA = W'($urandom) << 64 | W'($urandom) << 32 | W'($urandom);
    applyStimulus(1'b1, 1'b1, blkA[W-1], 1'b1, 1'b0);
    for (int i = 1; i < W; i++) applyStimulus(1'b1, 1'b1, blkA[W-1-i], 1'b0, 1'b0);
    cmp("resync block", bus.DataOUT, blkA);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: A then B without ack, then ack and C
    sendRandomBlock(blkA, 1'b0);
    sendRandomBlock(blkB, 1'b0);
    cmp("overrun keeps A", bus.DataOUT, blkA);
    cmp("overrun set", W'(bus.overrun), W'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sendRandomBlock(blkC, 1'b0);
    cmp("C loaded", bus.DataOUT, blkC);
    cmp("overrun sticky", W'(bus.overrun), W'(1));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp("overrun reset", W'(bus.overrun), W'(0));

    // Ack on the same edge as the next block load
    sendRandomBlock(blkA, 1'b0);
    sendRandomBlock(blkB, 1'b1);
    cmp("same-edge DataOUT", bus.DataOUT, blkB);
    cmp("same-edge valid", W'(bus.block_valid), W'(1));
    cmp("same-edge overrun", W'(bus.overrun), W'(0));

    // Random soak against the model
    for (int i = 0; i < 6000; i++) begin
      applyStimulus($urandom_range(0, 999) != 0,
                    $urandom_range(0, 9) < 8,
                    1'($urandom),
                    $urandom_range(0, 199) == 0,
                    $urandom_range(0, 19) == 0);
    end
    snap = bus.DataOUT;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cmp("sync keeps DataOUT", bus.DataOUT, snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
